student_iic_target: RTL and testbench

I2C target (responder) with a byte-wide register bank, forming the far end of the bus driven by the student I2C controller. It decodes START/STOP, matches a 7-bit address, and ACKs its own address. It accepts a register pointer followed by write data, and returns register contents on reads. It sits on the same open-drain SDA/SCL pins and exposes the register bank to hardware as a flat vector.

---
 rtl/student_iic_target_pkg.sv | 22 ++
 rtl/student_iic_target_sync.sv | 50 +++++
 rtl/student_iic_target.sv | 185 ++++++++++++++++++
 tb/tb_student_iic_target.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/student_iic_target_pkg.sv
// Shared types and constants for the student I2C target: FSM states, default bus
// address and the ACK/NACK bit levels seen on SDA.
package student_iic_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_ACK,
        ST_IGNORE
    } state_e;

    localparam logic [6:0] DEFAULT_ADDR = 7'h42;
    localparam logic       ACK_BIT      = 1'b0;
    localparam logic       NACK_BIT     = 1'b1;

endpackage

// File: rtl/student_iic_target_sync.sv
// Pin conditioner for one open-drain I2C line: 2-FF synchronizer, registered rise/fall
// detect, and a 3-sample majority filter when STUDENT_IIC_TARGET_GLITCH_FILTER_EN is defined.
module student_iic_target_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic clean;

`ifdef STUDENT_IIC_TARGET_GLITCH_FILTER_EN
    logic [1:0] hist;

    // Two agreeing samples out of three are needed to move the line, so a single-cycle spike never passes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist  <= 2'b11;
            clean <= 1'b1;
        end else begin
            hist  <= {hist[0], sync};
            clean <= (sync & hist[0]) | (sync & hist[1]) | (hist[0] & hist[1]);
        end
    end
`else
    assign clean = sync;
`endif

    // Reset to the idle-high bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta  <= 1'b1;
            sync  <= 1'b1;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            meta  <= pin;
            sync  <= meta;
            level <= clean;
            rise  <= clean & ~level;
            fall  <= ~clean & level;
        end
    end

endmodule

// File: rtl/student_iic_target.sv
// I2C target with an NREGS x 8-bit register bank: address match, pointer write, data write
// and sequential read. Define STUDENT_IIC_TARGET_GLITCH_FILTER_EN to filter the pins.
module student_iic_target
    import student_iic_target_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = DEFAULT_ADDR,
    parameter int         NREGS       = 8,
    localparam int        PW          = $clog2(NREGS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               sda_i,
    input  logic               scl_i,
    output logic               sda_oe,
    output logic [NREGS*8-1:0] regs_o,
    output logic               wr_pulse_o,
    output logic [PW-1:0]      wr_idx_o,
    output logic               busy_o
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    student_iic_target_sync u_scl_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .pin   (scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    student_iic_target_sync u_sda_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .pin   (sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic start_ev;
    logic stop_ev;
    assign start_ev = scl_lvl & sda_fall;
    assign stop_ev  = scl_lvl & sda_rise;

    state_e        state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          rw;
    logic [PW-1:0] ptr;
    logic [7:0]    cur_reg;
    logic          byte_done;
    logic          receiving;

    assign cur_reg   = regs_o[{ptr, 3'b000} +: 8];
    assign byte_done = scl_fall && (bit_cnt == 4'd8);
    assign receiving = (state == ST_ADDR) || (state == ST_PTR) || (state == ST_WR);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            rw         <= 1'b0;
            ptr        <= '0;
            sda_oe     <= 1'b0;
            regs_o     <= '0;
            wr_pulse_o <= 1'b0;
            wr_idx_o   <= '0;
            busy_o     <= 1'b0;
        end else begin
            wr_pulse_o <= 1'b0;
            // Bus conditions pre-empt whatever the byte engine is doing.
            if (stop_ev) begin
                state   <= ST_IDLE;
                sda_oe  <= 1'b0;
                busy_o  <= 1'b0;
                bit_cnt <= '0;
            end else if (start_ev) begin
                state   <= ST_ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
            end else begin
                if (scl_rise && receiving && (bit_cnt < 4'd8)) begin
                    shreg   <= {shreg[6:0], sda_lvl};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                case (state)
                    ST_IDLE: begin
                        bit_cnt <= '0;
                        sda_oe  <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (byte_done) begin
                            bit_cnt <= '0;
                            if (shreg[7:1] == TARGET_ADDR) begin
                                state  <= ST_ADDR_ACK;
                                sda_oe <= 1'b1;
                                busy_o <= 1'b1;
                                rw     <= shreg[0];
                            end else begin
                                state  <= ST_IGNORE;
                                sda_oe <= 1'b0;
                                busy_o <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                state  <= ST_RD;
                                shreg  <= cur_reg;
                                sda_oe <= ~cur_reg[7];
                            end else begin
                                state  <= ST_PTR;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_PTR: begin
                        if (byte_done) begin
                            bit_cnt <= '0;
                            ptr     <= shreg[PW-1:0];
                            sda_oe  <= 1'b1;
                            state   <= ST_PTR_ACK;
                        end
                    end
                    ST_WR: begin
                        if (byte_done) begin
                            bit_cnt                    <= '0;
                            regs_o[{ptr, 3'b000} +: 8] <= shreg;
                            wr_pulse_o                 <= 1'b1;
                            wr_idx_o                   <= ptr;
                            ptr                        <= ptr + PW'(1);
                            sda_oe                     <= 1'b1;
                            state                      <= ST_WR_ACK;
                        end
                    end
                    ST_PTR_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= ST_WR;
                        end
                    end
                    ST_RD: begin
                        // Bit 7 went out when the byte was loaded; each fall presents the next bit.
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                sda_oe  <= 1'b0;
                                state   <= ST_RD_ACK;
                            end else begin
                                shreg   <= {shreg[6:0], 1'b0};
                                sda_oe  <= ~shreg[6];
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_lvl == NACK_BIT) begin
                                state <= ST_IGNORE;
                            end else begin
                                ptr <= ptr + PW'(1);
                            end
                        end else if (scl_fall) begin
                            shreg  <= cur_reg;
                            sda_oe <= ~cur_reg[7];
                            state  <= ST_RD;
                        end
                    end
                    ST_IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_student_iic_target.sv
// Bench for student_iic_target: bit-level I2C controller driver on a wired-AND SDA,
// a register model, and expected-value queues for register writes and read data.
module tb_student_iic_target;
    import student_iic_target_pkg::*;

    localparam int NREGS = 8;
    localparam int Q     = 8;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic               scl     = 1'b1;
    logic               sda_ctl = 1'b1;
    logic               sda_line;
    logic               sda_oe;
    logic               wr_pulse;
    logic               busy;
    logic [NREGS*8-1:0] regs;
    logic [2:0]         wr_idx;

    assign sda_line = sda_ctl & ~sda_oe;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    student_iic_target #(
        .TARGET_ADDR (7'h42),
        .NREGS       (NREGS)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .sda_i      (sda_line),
        .scl_i      (scl),
        .sda_oe     (sda_oe),
        .regs_o     (regs),
        .wr_pulse_o (wr_pulse),
        .wr_idx_o   (wr_idx),
        .busy_o     (busy)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    logic [7:0]  model [NREGS];
    logic [15:0] wr_exp_q [$];
    logic [7:0]  rd_exp_q [$];
    int          wr_cnt = 0;
    logic [15:0] wr_e;

    function automatic logic [63:0] model_vec();
        logic [63:0] v;
        for (int k = 0; k < NREGS; k++) v[k*8 +: 8] = model[k];
        return v;
    endfunction

    // Write scoreboard: every strobe must match the oldest expected {index, data}.
    always @(negedge clk) begin
        if (rst_n && wr_pulse) begin
            wr_cnt++;
            check("wr_expected", wr_exp_q.size() != 0, 1'b1);
            if (wr_exp_q.size() != 0) begin
                wr_e = wr_exp_q.pop_front();
                check("wr_idx", wr_idx, wr_e[10:8]);
                check("wr_data", regs[int'(wr_e[10:8])*8 +: 8], wr_e[7:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic q_wait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_ctl = 1'b1; q_wait();
        scl = 1'b1;     q_wait();
        sda_ctl = 1'b0; q_wait();
        scl = 1'b0;     q_wait();
    endtask

    task automatic i2c_stop();
        sda_ctl = 1'b0; q_wait();
        scl = 1'b1;     q_wait();
        sda_ctl = 1'b1; q_wait();
    endtask

    task automatic send_bit(input logic b, output logic seen);
        sda_ctl = b; q_wait();
        scl = 1'b1;  q_wait();
        seen = sda_line;
        q_wait();
        scl = 1'b0;  q_wait();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) send_bit(b[i], dummy);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        logic [7:0] v;
        logic       s;
        logic       dummy;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            v[i] = s;
        end
        send_bit(ack_bit, dummy);
        d = v;
    endtask

    task automatic write_seq(input string tag, input logic [7:0] p, input logic [7:0] d0,
                             input logic [7:0] d1, input int n);
        logic       ack;
        logic [2:0] idx;
        logic [7:0] d;
        i2c_start();
        write_byte(8'h84, ack);
        check({tag, "_addr_ack"}, ack, ACK_BIT);
        check({tag, "_busy"}, busy, 1'b1);
        write_byte(p, ack);
        check({tag, "_ptr_ack"}, ack, ACK_BIT);
        idx = p[2:0];
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? d0 : d1;
            wr_exp_q.push_back({5'b0, idx, d});
            model[idx] = d;
            write_byte(d, ack);
            check({tag, "_data_ack"}, ack, ACK_BIT);
            idx = idx + 3'd1;
        end
        i2c_stop();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       ack;
        logic       dummy;
        logic [7:0] rd;
        int         pulses;

        for (int k = 0; k < NREGS; k++) model[k] = 8'h00;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_pulse", wr_pulse, 1'b0);
        check("rst_wr_idx", wr_idx, 3'd0);
        check("rst_regs", regs, 64'h0);

        // Single write to reg 3.
        pulses = wr_cnt;
        write_seq("t1", 8'h03, 8'hA5, 8'h00, 1);
        check("t1_busy_after_stop", busy, 1'b0);
        check("t1_reg3", regs[31:24], 8'hA5);
        check("t1_pulses", wr_cnt - pulses, 1);

        // Pointer wraps from the last register to register 0.
        pulses = wr_cnt;
        write_seq("t2", 8'h07, 8'h11, 8'h22, 2);
        check("t2_reg7", regs[63:56], 8'h11);
        check("t2_reg0", regs[7:0], 8'h22);
        check("t2_pulses", wr_cnt - pulses, 2);

        // Preload, then pointer write + repeated START + two-byte read.
        write_seq("pre", 8'h02, 8'h5A, 8'hC3, 2);
        i2c_start();
        write_byte(8'h84, ack);
        check("t3_addr_ack", ack, ACK_BIT);
        write_byte(8'h02, ack);
        check("t3_ptr_ack", ack, ACK_BIT);
        i2c_start();
        write_byte(8'h85, ack);
        check("t3_rd_addr_ack", ack, ACK_BIT);
        check("t3_busy", busy, 1'b1);
        rd_exp_q.push_back(model[2]);
        rd_exp_q.push_back(model[3]);
        read_byte(ACK_BIT, rd);
        check("t3_rd0", rd, rd_exp_q.pop_front());
        read_byte(NACK_BIT, rd);
        check("t3_rd1", rd, rd_exp_q.pop_front());
        check("t3_oe_after_nack", sda_oe, 1'b0);
        i2c_stop();
        check("t3_busy_after_stop", busy, 1'b0);

        // Foreign address 0x43: no ACK, not busy, data ignored.
        pulses = wr_cnt;
        i2c_start();
        write_byte(8'h86, ack);
        check("t4_addr_nack", ack, NACK_BIT);
        check("t4_busy", busy, 1'b0);
        write_byte(8'h00, ack);
        check("t4_data_nack", ack, NACK_BIT);
        check("t4_regs", regs, model_vec());
        i2c_stop();
        check("t4_pulses", wr_cnt - pulses, 0);

        // STOP in the middle of a data byte.
        pulses = wr_cnt;
        i2c_start();
        write_byte(8'h84, ack);
        check("t5_addr_ack", ack, ACK_BIT);
        write_byte(8'h05, ack);
        check("t5_ptr_ack", ack, ACK_BIT);
        for (int i = 0; i < 4; i++) send_bit(1'b1, dummy);
        i2c_stop();
        check("t5_state", dut.state, ST_IDLE);
        check("t5_busy", busy, 1'b0);
        check("t5_sda_oe", sda_oe, 1'b0);
        check("t5_regs", regs, model_vec());
        check("t5_pulses", wr_cnt - pulses, 0);

`ifdef STUDENT_IIC_TARGET_GLITCH_FILTER_EN
        // One-cycle SDA dip with SCL high must not register as START.
        q_wait();
        sda_ctl = 1'b0;
        @(negedge clk);
        sda_ctl = 1'b1;
        repeat (12) @(negedge clk);
        check("t6_glitch_state", dut.state, ST_IDLE);
        check("t6_glitch_busy", busy, 1'b0);
`endif

        // Reset while the target is pulling SDA low for the address ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(((8'h84 >> i) & 8'h01) != 0, dummy);
        check("t7_ack_drive", sda_oe, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t7_rst_sda_oe", sda_oe, 1'b0);
        check("t7_rst_busy", busy, 1'b0);
        check("t7_rst_regs", regs, 64'h0);
        rst_n = 1'b1;
        for (int k = 0; k < NREGS; k++) model[k] = 8'h00;
        sda_ctl = 1'b1; q_wait();
        scl = 1'b1;     q_wait();

        check("end_wr_queue", wr_exp_q.size(), 0);
        check("end_rd_queue", rd_exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        repeat (40000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected run to complete");
        $fatal(1, "cycle budget exhausted");
    end

endmodule
